// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, FSM state encoding and bit-level helpers.
// Bit numbering follows FIPS 46: bit 1 is the MSB of each vector.
package des_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned NumSubkeys = 16;

    localparam logic [5:0] PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam logic [5:0] PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TBL [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Selects the 56 non-parity key bits into C (upper 28) and D (lower 28).
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[6'(64 - PC1_TBL[i])];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: compresses the 56-bit C/D pair into a 48-bit subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int i = 0; i < 48; i++) begin
            subkey[47-i] = cd[6'd56 - PC2_TBL[i]];
        end
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule sequencer: loads PC-1(key) on start and streams 16 round
// subkeys in encrypt or decrypt order over a valid/ready handshake.
module des_key_sched_ctrl
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        ready,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk_data,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        done
);

    localparam logic [3:0] LastCnt = 4'(ROUNDS - 1);

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;

    logic        accept;
    logic        handshake;
    logic        last;
    logic [55:0] cd_pc1;
    logic [27:0] c_load, d_load;
    logic [47:0] pc2_out;

    assign accept    = (state_q == StIdle) && start;
    assign handshake = (state_q == StIssue) && sk_ready;
    assign last      = (cnt_q == LastCnt);
    assign cd_pc1    = pc1(key);

    // Encrypt folds the first shift into the load so the registers always hold
    // the C/D of the subkey being presented; decrypt starts at C16 == C0.
    assign c_load = decrypt ? cd_pc1[55:28] : rotl28(cd_pc1[55:28], SHIFT_TBL[0]);
    assign d_load = decrypt ? cd_pc1[27:0]  : rotl28(cd_pc1[27:0],  SHIFT_TBL[0]);

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (pc2_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if (sk_ready && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        sk_valid = 1'b0;
        sk_last  = 1'b0;
        sk_round = '0;
        sk_data  = '0;
        done     = 1'b0;
        unique case (state_q)
            StIdle:  ready = 1'b1;
            StIssue: begin
                sk_valid = 1'b1;
                sk_last  = last;
                sk_round = dec_q ? (LastCnt - cnt_q) : cnt_q;
                sk_data  = pc2_out;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // The final handshake leaves C/D and the counter alone so nothing wraps.
    always_comb begin
        c_d   = c_q;
        d_d   = d_q;
        cnt_d = cnt_q;
        dec_d = dec_q;
        if (accept) begin
            c_d   = c_load;
            d_d   = d_load;
            cnt_d = '0;
            dec_d = decrypt;
        end else if (handshake && !last) begin
            cnt_d = cnt_q + 4'd1;
            if (dec_q) begin
                c_d = rotr28(c_q, SHIFT_TBL[LastCnt - cnt_q]);
                d_d = rotr28(d_q, SHIFT_TBL[LastCnt - cnt_q]);
            end else begin
                c_d = rotl28(c_q, SHIFT_TBL[cnt_q + 4'd1]);
                d_d = rotl28(d_q, SHIFT_TBL[cnt_q + 4'd1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            dec_q <= 1'b0;
        end else begin
            c_q   <= c_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
            dec_q <= dec_d;
        end
    end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench for des_key_sched_ctrl using the classic 133457799BBCDFF1
// key vectors plus an all-ones key whose subkeys are trivially all ones.
module tb_des_key_sched_ctrl;

    localparam logic [63:0] Key1    = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] KeyOnes = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct packed {
        logic [47:0] data;
        logic [3:0]  round;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        ready;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] sk_data;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        done;

    exp_t sb[$];
    int   done_exp = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    des_key_sched_ctrl #(.ROUNDS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .decrypt  (decrypt),
        .key      (key),
        .ready    (ready),
        .sk_valid (sk_valid),
        .sk_ready (sk_ready),
        .sk_data  (sk_data),
        .sk_round (sk_round),
        .sk_last  (sk_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_round(input bit dec, input int pos);
        return dec ? 15 - pos : pos;
    endfunction

    function automatic logic [47:0] exp_data(input bit dec, input bit ones, input int pos);
        return ones ? 48'hFFFF_FFFF_FFFF : KS[exp_round(dec, pos)];
    endfunction

    task automatic push_exp(input bit dec, input bit ones, input int count);
        for (int i = 0; i < count; i++) begin
            sb.push_back('{data: exp_data(dec, ones, i), round: 4'(exp_round(dec, i)),
                           last: (i == 15)});
        end
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (!ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ready_before_start", 64'(ready), 64'(1));
    endtask

    // One complete job; optional stall, start-poke during ISSUE, or chained start.
    task automatic do_job(input logic [63:0] k, input bit dec, input bit ones,
                          input int stall_at, input int stall_len, input bit poke,
                          input bit chain, input logic [63:0] nk, input bit nd);
        int hs, cyc, stalled;
        bit in_stall;
        push_exp(dec, ones, 16);
        done_exp++;
        wait_ready();
        start = 1'b1; key = k; decrypt = dec;
        @(posedge clk); #1;
        if (chain) begin
            key = nk; decrypt = nd;
        end else begin
            start = 1'b0; key = ~k; decrypt = ~dec;
        end
        chk("first_valid_latency", 64'(sk_valid), 64'(1));
        hs = 0; cyc = 0; stalled = 0;
        while (hs < 16 && cyc < 200) begin
            in_stall = (stall_at >= 0) && (hs == stall_at) && (stalled < stall_len);
            if (in_stall) stalled++;
            sk_ready = !in_stall;
            if (poke && cyc == 4) begin
                start = 1'b1; key = '0;
            end else if (poke && cyc == 5) begin
                start = 1'b0; key = ~k;
            end
            @(negedge clk);
            if (poke && cyc == 4) chk("ready_low_in_issue", 64'(ready), 64'(0));
            if (in_stall) begin
                chk("stall_hold_data", 64'(sk_data), 64'(exp_data(dec, ones, hs)));
                chk("stall_hold_round", 64'(sk_round), 64'(exp_round(dec, hs)));
                chk("stall_valid", 64'(sk_valid), 64'(1));
            end
            if (sk_valid && sk_ready) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        sk_ready = 1'b1;
        chk("handshake_count", 64'(hs), 64'(16));
        chk("done_latency", 64'(cyc), 64'(16 + stall_len));
        chk("done_pulse", 64'(done), 64'(1));
        chk("ready_in_done", 64'(ready), 64'(0));
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("ready_after_done", 64'(ready), 64'(1));
    endtask

    // Encrypt job aborted by reset while round 7 is presented.
    task automatic abort_job(input logic [63:0] k);
        int hs, cyc;
        push_exp(1'b0, 1'b0, 7);
        wait_ready();
        start = 1'b1; key = k; decrypt = 1'b0; sk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 7 && cyc < 50) begin
            @(negedge clk);
            if (sk_valid && sk_ready) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_at_round", 64'(sk_round), 64'(7));
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("abort_ready", 64'(ready), 64'(1));
        chk("abort_valid", 64'(sk_valid), 64'(0));
        chk("abort_last", 64'(sk_last), 64'(0));
        chk("abort_data", 64'(sk_data), 64'(0));
        repeat (3) begin
            chk("abort_no_done", 64'(done), 64'(0));
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every accepted subkey and every done pulse is matched to the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sk_valid && sk_ready) begin
                chk("subkey_expected", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sk_data", 64'(sk_data), 64'(e.data));
                    chk("sk_round", 64'(sk_round), 64'(e.round));
                    chk("sk_last", 64'(sk_last), 64'(e.last));
                end
            end
            if (!rst && done) begin
                chk("done_expected", 64'(done_exp != 0), 64'(1));
                if (done_exp != 0) done_exp--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; sk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready), 64'(1));
        chk("reset_valid", 64'(sk_valid), 64'(0));
        chk("reset_last", 64'(sk_last), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_round", 64'(sk_round), 64'(0));
        chk("reset_data", 64'(sk_data), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Encrypt with an ignored start (key=0) issued mid-job.
        do_job(Key1, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0, '0, 1'b0);
        // Decrypt order.
        do_job(Key1, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, '0, 1'b0);
        // Three-cycle backpressure at round 4.
        do_job(Key1, 1'b0, 1'b0, 4, 3, 1'b0, 1'b0, '0, 1'b0);
        // Reset abort, then a clean encrypt job.
        abort_job(Key1);
        do_job(Key1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, '0, 1'b0);
        // Back-to-back with start held high into a second key.
        do_job(Key1, 1'b1, 1'b0, -1, 0, 1'b0, 1'b1, KeyOnes, 1'b0);
        do_job(KeyOnes, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, '0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        chk("all_done_seen", 64'(done_exp), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
